// File: rtl/tone_freq_meter_pkg.sv
// Shared constants, state encoding and width helpers for the tone meter.
// Optional amplitude output is enabled by TONE_FREQ_METER_AMPLITUDE_EN.
package tone_freq_meter_pkg;

  localparam int DEF_SAMPLE_BITS = 12;
  localparam int DEF_FREQ_BITS   = 15;
  localparam int DEF_PHASE_BITS  = 24;
  localparam int DEF_LOG_AVG     = 2;
  localparam int DEF_HYST        = 64;
  localparam int DEF_CNT_BITS    = 26;

  localparam int DEF_QW = DEF_PHASE_BITS + DEF_LOG_AVG + 1;
  localparam int DEF_DW = DEF_CNT_BITS;

  localparam logic [DEF_SAMPLE_BITS-1:0] DEF_MID = 12'h800;
  localparam logic [DEF_FREQ_BITS-1:0] DEF_FREQ_SAT = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/meter_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// start is ignored while busy; done pulses for one cycle with quotient valid.
module meter_divider
  import tone_freq_meter_pkg::*;
#(
  parameter int QW = DEF_QW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = cnt_width(QW);

  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] dsr;
  logic [QW-1:0] quo;
  logic [DW:0]   trial;
  logic [DW-1:0] diff;
  logic          fits;

  assign trial    = {rem, quo[QW-1]};
  assign fits     = trial >= {1'b0, dsr};
  assign diff     = DW'(trial - {1'b0, dsr});
  assign busy     = cnt != '0;
  assign quotient = quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      rem  <= '0;
      dsr  <= '0;
      quo  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          cnt <= CW'(QW);
          rem <= '0;
          dsr <= divisor;
          quo <= dividend;
        end
      end else begin
        cnt <= cnt - CW'(1);
        rem <= fits ? diff : trial[DW-1:0];
        quo <= {quo[QW-2:0], fits};
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_freq_meter.sv
// Tone frequency meter: times 2^LOG_AVG midpoint crossings, divides into a tuning word.
// TONE_FREQ_METER_AMPLITUDE_EN adds a peak-to-peak amplitude output.
module tone_freq_meter
  import tone_freq_meter_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int FREQ_BITS   = DEF_FREQ_BITS,
  parameter int PHASE_BITS  = DEF_PHASE_BITS,
  parameter int LOG_AVG     = DEF_LOG_AVG,
  parameter int HYST        = DEF_HYST,
  parameter int CNT_BITS    = DEF_CNT_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SAMPLE_BITS-1:0] wave,
  input  logic                   wave_valid,
  output logic [FREQ_BITS-1:0]   frequency,
  output logic                   freq_valid,
  output logic                   no_signal
`ifdef TONE_FREQ_METER_AMPLITUDE_EN
  ,
  output logic [SAMPLE_BITS-1:0] amplitude
`endif
);

  localparam int QW    = PHASE_BITS + LOG_AVG + 1;
  localparam int PW    = LOG_AVG + 1;
  localparam int PER_N = 1 << LOG_AVG;

  localparam logic [SAMPLE_BITS-1:0] MID =
    SAMPLE_BITS'(1) << (SAMPLE_BITS - 1);
  localparam logic [SAMPLE_BITS-1:0] ARM_LVL =
    MID - SAMPLE_BITS'(HYST);
  localparam logic [QW-1:0] DIVIDEND =
    QW'(1) << (PHASE_BITS + LOG_AVG);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0] PER_LAST = PW'(PER_N - 1);
  localparam logic [FREQ_BITS-1:0] FREQ_SAT = '1;

  meter_state_e        state;
  logic [CNT_BITS-1:0] win_cnt;
  logic [PW-1:0]       per_cnt;
  logic                armed;
  logic                xing;
  logic                xing_q;
  logic                timeout;
  logic                win_close;
  logic                close_ok;
  logic                win_start;
  logic                run;
  logic                div_start;
  logic [CNT_BITS-1:0] div_divisor;
  logic                div_busy;
  logic                div_done;
  logic [QW-1:0]       div_q;

  assign xing = armed & wave_valid & (wave >= MID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      xing_q <= 1'b0;
    end else begin
      xing_q <= xing;
      if (xing) armed <= 1'b0;
      else if (wave_valid && wave < ARM_LVL) armed <= 1'b1;
    end
  end

  assign timeout   = (state == MEASURE) && (win_cnt == CNT_MAX);
  assign win_close = (state == MEASURE) && !timeout &&
                     xing_q && (per_cnt == PER_LAST);
  // A close while the divider is occupied is dropped but still restarts
  assign close_ok  = win_close && !div_busy && !div_start;
  assign win_start = ((state == IDLE) && xing_q) || win_close;
  assign run       = (state == MEASURE) && !timeout && !win_close;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win_cnt     <= '0;
      per_cnt     <= '0;
      div_start   <= 1'b0;
      div_divisor <= '0;
    end else begin
      div_start <= close_ok;
      if (close_ok) div_divisor <= win_cnt + CNT_BITS'(1);
      unique case (state)
        IDLE:    if (xing_q) state <= MEASURE;
        MEASURE: if (timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
      unique case (1'b1)
        win_start: begin
          win_cnt <= '0;
          per_cnt <= '0;
        end
        run: begin
          win_cnt <= win_cnt + CNT_BITS'(1);
          if (xing_q) per_cnt <= per_cnt + PW'(1);
        end
        default: ;
      endcase
    end
  end

  meter_divider #(
    .QW(QW),
    .DW(CNT_BITS)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frequency  <= '0;
      freq_valid <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      freq_valid <= div_done;
      if (div_done) begin
        frequency <= |div_q[QW-1:FREQ_BITS] ? FREQ_SAT
                   : div_q[FREQ_BITS-1:0];
        no_signal <= 1'b0;
      end
      if (timeout) no_signal <= 1'b1;
    end
  end

`ifdef TONE_FREQ_METER_AMPLITUDE_EN
  logic [SAMPLE_BITS-1:0] amp_max;
  logic [SAMPLE_BITS-1:0] amp_min;
  logic [SAMPLE_BITS-1:0] amp_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_max   <= '0;
      amp_min   <= '1;
      amp_win   <= '0;
      amplitude <= '0;
    end else begin
      if (close_ok)
        amp_win <= (amp_max >= amp_min) ? amp_max - amp_min : '0;
      if (win_start) begin
        amp_max <= '0;
        amp_min <= '1;
      end else if (wave_valid) begin
        if (wave > amp_max) amp_max <= wave;
        if (wave < amp_min) amp_min <= wave;
      end
      if (div_done) amplitude <= amp_win;
    end
  end
`endif

endmodule

// File: tb/tb_tone_freq_meter.sv
// Bench for tone_freq_meter: nco/square stimulus against a crossing-timestamp model.
// Window counter shortened so the timeout is reachable in a short run.
module tb_tone_freq_meter;

  localparam int     CNT_BITS = 14;
  localparam longint CNT_MAX  = (64'd1 << CNT_BITS) - 1;
  localparam longint DVD      = 64'd1 << 26;
  localparam int     LAT      = 29;
  localparam real    PI       = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] wave = 12'h800;
  logic        wave_valid = 1'b0;
  logic [14:0] frequency;
  logic        freq_valid;
  logic        no_signal;
`ifdef TONE_FREQ_METER_AMPLITUDE_EN
  logic [11:0] amplitude;
`endif

  tone_freq_meter #(.CNT_BITS(CNT_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wave       (wave),
    .wave_valid (wave_valid),
    .frequency  (frequency),
    .freq_valid (freq_valid),
`ifdef TONE_FREQ_METER_AMPLITUDE_EN
    .amplitude  (amplitude),
`endif
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input longint act,
                           input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Model: crossing timestamps -> windows -> quotient schedule
  longint edge_n = 0;
  bit     m_armed, m_xq, m_meas;
  longint m_start, m_last_acc;
  int     m_per;
  longint pq_edge[$];
  longint pq_val[$];
  longint m_freq;
  bit     m_fv, m_nos;
  int     m_pulses = 0;
  int     dut_pulses = 0;

  function automatic longint sat15(input longint q);
    return (q > 32767) ? 32767 : q;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_xq = 0; m_meas = 0; m_per = 0;
    m_start = 0; m_last_acc = -1000;
    pq_edge.delete(); pq_val.delete();
    m_freq = 0; m_fv = 0; m_nos = 1;
  endtask

  task automatic model_step();
    bit tmo;
    longint t;
    tmo = 0;
    m_fv = 0;
    if (m_meas && edge_n - m_start - 1 == CNT_MAX) begin
      tmo = 1;
      m_meas = 0;
    end else if (m_xq) begin
      if (!m_meas) begin
        m_meas = 1; m_start = edge_n; m_per = 0;
      end else begin
        m_per++;
        if (m_per == 4) begin
          t = edge_n - m_start;
          if (edge_n - m_last_acc >= LAT) begin
            pq_edge.push_back(edge_n + LAT);
            pq_val.push_back(sat15(DVD / t));
            m_last_acc = edge_n;
          end
          m_start = edge_n;
          m_per = 0;
        end
      end
    end
    if (pq_edge.size() > 0 && pq_edge[0] == edge_n) begin
      void'(pq_edge.pop_front());
      m_freq = pq_val.pop_front();
      m_fv = 1; m_nos = 0; m_pulses++;
    end
    if (tmo) m_nos = 1;
    m_xq = m_armed && wave_valid && wave >= 12'h800;
    if (m_xq) m_armed = 0;
    else if (wave_valid && wave < 12'h7C0) m_armed = 1;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    #1;
    edge_n++;
    if (!rst_n) model_reset();
    else model_step();
    check("freq_valid", freq_valid, m_fv);
    check("frequency", frequency, m_freq);
    check("no_signal", no_signal, m_nos);
    if (freq_valid) dut_pulses++;
  end

  // Stimulus sources
  int          mode = 0;
  logic [23:0] phase = '0;
  logic [23:0] fw = '0;
  int          sq_per = 1024, sq_cnt = 0;
  logic [11:0] sq_lo = 12'h000, sq_hi = 12'hFFF;
  logic [11:0] dc_val = 12'h800;

  task automatic cycle();
    int w;
    @(negedge clk);
    case (mode)
      1: begin
        phase = phase + fw;
        w = 2048 + $rtoi(2047.0 *
            $sin(2.0 * PI * real'(phase) / 16777216.0));
        wave = 12'(w);
      end
      2: begin
        sq_cnt = (sq_cnt + 1) % sq_per;
        wave = (sq_cnt < sq_per / 2) ? sq_lo : sq_hi;
      end
      default: wave = dc_val;
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_pulses(input string nm, input int n,
                             input int limit);
    int s, c;
    s = m_pulses;
    c = 0;
    while (m_pulses - s < n && c < limit) begin
      cycle();
      c++;
    end
    check(nm, m_pulses - s, n);
  endtask

  task automatic wait_nosig(input int limit);
    int c;
    c = 0;
    while (!m_nos && c < limit) begin
      cycle();
      c++;
    end
    check("t3_timeout_reached", m_nos, 1);
  endtask

  int p0;

  initial begin
    run(4);
    check("rst_frequency", frequency, 0);
    check("rst_freq_valid", freq_valid, 0);
    check("rst_no_signal", no_signal, 1);

    mode = 1; fw = 24'd20000; wave_valid = 1'b1;
    rst_n = 1'b1;
    wait_pulses("t1_first_within_5000", 1, 5000);
    check_rng("t1_freq", frequency, 19990, 20010);
    check("t1_no_signal", no_signal, 0);
`ifdef TONE_FREQ_METER_AMPLITUDE_EN
    check("t1_amp_full_scale", amplitude >= 12'hFF0, 1);
`endif
    wait_pulses("t1_second", 1, 5000);
    check_rng("t1_freq2", frequency, 19990, 20010);

    fw = 24'd5000;
    wait_pulses("t2_mixed", 1, 20000);
    wait_pulses("t2_settled", 1, 20000);
    check_rng("t2_freq", frequency, 4995, 5005);

    mode = 0; dc_val = 12'h800;
    p0 = dut_pulses;
    wait_nosig(20000);
    run(2);
    check("t3_no_signal", no_signal, 1);
    check_rng("t3_freq_held", frequency, 4995, 5005);
    check("t3_no_pulse", dut_pulses - p0, 0);

    mode = 2; sq_per = 64; sq_lo = 12'h7C0; sq_hi = 12'h840;
    p0 = dut_pulses;
    run(2000);
    check("t4_hyst_no_pulse", dut_pulses - p0, 0);
    check("t4_hyst_no_signal", no_signal, 1);

    mode = 1; fw = 24'd20000;
    wait_pulses("t3_reapply", 1, 6000);
    check("t3_reapply_no_signal", no_signal, 0);
    check_rng("t3_reapply_freq", frequency, 19990, 20010);

    mode = 2; sq_per = 1024; sq_cnt = 0;
    sq_lo = 12'h000; sq_hi = 12'hFFF;
    wait_pulses("t4_square", 2, 12000);
    check("t4_freq", frequency, 16384);

    sq_per = 256; sq_cnt = 0;
    wait_pulses("t5_square", 2, 4000);
    check("t5_sat", frequency, 15'h7FFF);

    begin : t6
      int c;
      c = 0;
      while (pq_edge.size() == 0 && c < 3000) begin
        cycle();
        c++;
      end
      check("t6_divide_pending", pq_edge.size(), 1);
    end
    run(10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_frequency", frequency, 0);
    check("t6_rst_freq_valid", freq_valid, 0);
    check("t6_rst_no_signal", no_signal, 1);
    p0 = dut_pulses;
    run(3);
    rst_n = 1'b1;
    run(40);
    check("t6_no_stale_pulse", dut_pulses - p0, 0);
    wait_pulses("t6_remeasure", 1, 3000);
    check("t6_freq", frequency, 15'h7FFF);
    check("t6_no_signal", no_signal, 0);

    run(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
